// File: rtl/door_controller_1315.sv
// Motorised door controller: button/sensor/light-barrier driven FSM with flashing warning and courtesy lights.
// Optional run-time limit into FAULT is compiled in with `define DOOR_RUN_TIMEOUT_EN.
module door_controller_1315 #(
  parameter int unsigned FLASH_DIV    = 32'd2,
  parameter int unsigned LIGHT_CYCLES = 32'd10,
  parameter int unsigned MAX_RUN      = 32'd64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic buttonup,
  input  logic buttondown,
  input  logic sensortop,
  input  logic sensorbottom,
  input  logic lightbarrier,
  output logic motorleft,
  output logic motorright,
  output logic lightsteady,
  output logic lightflash
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_CLOSED  = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam int unsigned FW = (FLASH_DIV > 32'd1) ? $clog2(FLASH_DIV) : 32'd1;
  localparam int unsigned LW = $clog2(LIGHT_CYCLES + 32'd1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 32'd1);
  localparam logic [LW-1:0] LIGHT_LOAD = LW'(LIGHT_CYCLES);

  state_e         state_q, state_d;
  logic [FW-1:0]  flash_cnt_q, flash_cnt_d;
  logic           flash_ph_q, flash_ph_d;
  logic [LW-1:0]  light_cnt_q, light_cnt_d;
  logic           motorleft_q, motorleft_d;
  logic           motorright_q, motorright_d;
  logic           lightsteady_q, lightsteady_d;
  logic           lightflash_q, lightflash_d;

  logic up_req_s, dn_req_s, both_sens_s, moving_d_s, parked_d_s, entered_s;
  logic run_expired_s;

  // Pressing both buttons at once counts as no request at all.
  assign up_req_s    = buttonup & ~buttondown;
  assign dn_req_s    = buttondown & ~buttonup;
  assign both_sens_s = sensortop & sensorbottom;

`ifdef DOOR_RUN_TIMEOUT_EN
  localparam int unsigned RW = (MAX_RUN > 32'd1) ? $clog2(MAX_RUN) : 32'd1;
  localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN - 32'd1);

  logic [RW-1:0] run_cnt_q, run_cnt_d;

  // Run-time counter restarts whenever a new motion (or reversal) begins.
  always_comb begin
    run_cnt_d = {RW{1'b0}};
    if (moving_d_s && !entered_s) begin
      if (run_cnt_q != RUN_LAST) begin
        run_cnt_d = run_cnt_q + RW'(1);
      end else begin
        run_cnt_d = run_cnt_q;
      end
    end else begin
      run_cnt_d = {RW{1'b0}};
    end
  end

  // Run-time counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= {RW{1'b0}};
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign run_expired_s = (run_cnt_q == RUN_LAST);
`else
  logic unused_run_s;
  assign unused_run_s  = ^(32'(MAX_RUN));
  assign run_expired_s = 1'b0;
`endif

  // Next-state decode; a double end-stop reading overrides every state.
  always_comb begin
    state_d = state_q;
    if (both_sens_s) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sensortop)         state_d = ST_OPEN;
          else if (sensorbottom) state_d = ST_CLOSED;
          else                   state_d = ST_OPENING;
        end
        ST_OPENING: begin
          if (sensortop)                          state_d = ST_OPEN;
          else if (run_expired_s)                 state_d = ST_FAULT;
          else if (dn_req_s && !lightbarrier)     state_d = ST_CLOSING;
          else                                    state_d = ST_OPENING;
        end
        ST_OPEN: begin
          if (dn_req_s && !lightbarrier) state_d = ST_CLOSING;
          else                           state_d = ST_OPEN;
        end
        ST_CLOSING: begin
          if (lightbarrier)       state_d = ST_OPENING;
          else if (sensorbottom)  state_d = ST_CLOSED;
          else if (run_expired_s) state_d = ST_FAULT;
          else if (up_req_s)      state_d = ST_OPENING;
          else                    state_d = ST_CLOSING;
        end
        ST_CLOSED: begin
          if (up_req_s) state_d = ST_OPENING;
          else          state_d = ST_CLOSED;
        end
        ST_FAULT: state_d = ST_INIT;
        default:  state_d = ST_INIT;
      endcase
    end
  end

  assign moving_d_s = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
  assign parked_d_s = (state_d == ST_OPEN) || (state_d == ST_CLOSED);
  assign entered_s  = (state_d != state_q);

  // Flash phase restarts high on every motion entry; courtesy timer loads on every park entry.
  always_comb begin
    flash_cnt_d = {FW{1'b0}};
    flash_ph_d  = 1'b0;
    light_cnt_d = {LW{1'b0}};
    if (moving_d_s) begin
      if (entered_s) begin
        flash_cnt_d = {FW{1'b0}};
        flash_ph_d  = 1'b1;
      end else if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = {FW{1'b0}};
        flash_ph_d  = ~flash_ph_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FW'(1);
        flash_ph_d  = flash_ph_q;
      end
    end else begin
      flash_cnt_d = {FW{1'b0}};
      flash_ph_d  = 1'b0;
    end
    if (parked_d_s) begin
      if (entered_s)                        light_cnt_d = LIGHT_LOAD;
      else if (light_cnt_q != {LW{1'b0}})   light_cnt_d = light_cnt_q - LW'(1);
      else                                  light_cnt_d = light_cnt_q;
    end else begin
      light_cnt_d = {LW{1'b0}};
    end
  end

  // Output decode from next-state values so the output registers track the state register.
  always_comb begin
    motorleft_d   = (state_d == ST_OPENING);
    motorright_d  = (state_d == ST_CLOSING);
    lightsteady_d = moving_d_s || (parked_d_s && (light_cnt_d != {LW{1'b0}}));
    lightflash_d  = moving_d_s ? flash_ph_d : (state_d == ST_FAULT);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      flash_cnt_q   <= {FW{1'b0}};
      flash_ph_q    <= 1'b0;
      light_cnt_q   <= {LW{1'b0}};
      motorleft_q   <= 1'b0;
      motorright_q  <= 1'b0;
      lightsteady_q <= 1'b0;
      lightflash_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_ph_q    <= flash_ph_d;
      light_cnt_q   <= light_cnt_d;
      motorleft_q   <= motorleft_d;
      motorright_q  <= motorright_d;
      lightsteady_q <= lightsteady_d;
      lightflash_q  <= lightflash_d;
    end
  end

  assign motorleft   = motorleft_q;
  assign motorright  = motorright_q;
  assign lightsteady = lightsteady_q;
  assign lightflash  = lightflash_q;

endmodule

// File: tb/tb_door_controller_1315.sv
// Directed bench for door_controller_1315 with default parameters (FLASH_DIV=2, LIGHT_CYCLES=10).
module tb_door_controller_1315;

  logic clk = 1'b0;
  logic rst_n, buttonup, buttondown, sensortop, sensorbottom, lightbarrier;
  logic motorleft, motorright, lightsteady, lightflash;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  door_controller_1315 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttonup     (buttonup),
    .buttondown   (buttondown),
    .sensortop    (sensortop),
    .sensorbottom (sensorbottom),
    .lightbarrier (lightbarrier),
    .motorleft    (motorleft),
    .motorright   (motorright),
    .lightsteady  (lightsteady),
    .lightflash   (lightflash)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic ml, input logic mr, input logic ls, input logic lf);
    chk({tag, ".motorleft"},   motorleft,   ml);
    chk({tag, ".motorright"},  motorright,  mr);
    chk({tag, ".lightsteady"}, lightsteady, ls);
    chk({tag, ".lightflash"},  lightflash,  lf);
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; buttonup = 1'b0; buttondown = 1'b0;
    sensortop = 1'b0; sensorbottom = 1'b0; lightbarrier = 1'b0;
    repeat (2) @(negedge clk);
    chk4("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b1;
    cyc(1); chk4("ref_run", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1); chk("flash_e2", lightflash, 1'b1);
    cyc(1); chk("flash_e3", lightflash, 1'b0);
    cyc(1); chk("flash_e4", lightflash, 1'b0);
    cyc(1); chk("flash_e5", lightflash, 1'b1);

    sensortop = 1'b1;
    cyc(1); chk4("open_entry", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(9); chk("light_last", lightsteady, 1'b1);
    cyc(1); chk("light_off", lightsteady, 1'b0);

    lightbarrier = 1'b1; buttondown = 1'b1;
    cyc(1); chk4("barrier_blocks", 1'b0, 1'b0, 1'b0, 1'b0);
    lightbarrier = 1'b0; buttonup = 1'b1;
    cyc(1); chk4("both_btn_open", 1'b0, 1'b0, 1'b0, 1'b0);

    buttonup = 1'b0; sensortop = 1'b0;
    cyc(1); chk4("close_start", 1'b0, 1'b1, 1'b1, 1'b1);
    buttondown = 1'b0;
    cyc(1); chk("close_flash_e2", lightflash, 1'b1);
    cyc(1); chk("close_flash_e3", lightflash, 1'b0);

    lightbarrier = 1'b1;
    cyc(1); chk4("barrier_reverse", 1'b1, 1'b0, 1'b1, 1'b1);
    lightbarrier = 1'b0;

    buttondown = 1'b1;
    cyc(1); chk4("reverse_to_close", 1'b0, 1'b1, 1'b1, 1'b1);
    buttondown = 1'b0; buttonup = 1'b1;
    cyc(1); chk4("up_in_closing", 1'b1, 1'b0, 1'b1, 1'b1);
    buttonup = 1'b0; buttondown = 1'b1;
    cyc(1); chk4("close_again", 1'b0, 1'b1, 1'b1, 1'b1);
    buttondown = 1'b0; sensorbottom = 1'b1;
    cyc(1); chk4("closed", 1'b0, 1'b0, 1'b1, 1'b0);

    buttonup = 1'b1; buttondown = 1'b1;
    cyc(1); chk4("both_btn_closed", 1'b0, 1'b0, 1'b1, 1'b0);
    buttondown = 1'b0; sensorbottom = 1'b0;
    cyc(1); chk4("open_from_closed", 1'b1, 1'b0, 1'b1, 1'b1);
    buttonup = 1'b0; sensortop = 1'b1;
    cyc(1); chk4("open_again", 1'b0, 1'b0, 1'b1, 1'b0);

    sensorbottom = 1'b1;
    cyc(1); chk4("fault", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1); chk4("fault_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    sensorbottom = 1'b0;
    cyc(1); chk4("fault_exit_init", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1); chk4("init_to_open", 1'b0, 1'b0, 1'b1, 1'b0);

    sensortop = 1'b0; buttondown = 1'b1;
    cyc(1); chk("pre_reset_motion", motorright, 1'b1);
    buttondown = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk4("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    sensorbottom = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1); chk4("reset_to_closed", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
